imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Upstream feeder of the single-cycle MIPS core: receives a program as a byte stream (valid/ready),
//  assembles little-endian 32-bit words and writes them into instruction memory word by word.
//  Holds the core in reset (cpu_reset high) until a complete, valid image is loaded, then releases it.
//  The core then fetches from PC 0 = word address 0.
// PARAMETERS
//  ADDR_W     8   instruction-memory word-address width; capacity = 2**ADDR_W words
// PORTS
//  clock       in   1        system clock, all state on rising edge
//  Reset_n     in   1        asynchronous, active-low reset
//  start       in   1        begin a load; sampled in IDLE, DONE, ERROR
//  rx_data     in   8        stream byte
//  rx_valid    in   1        rx_data valid
//  rx_ready    out  1        loader accepts byte this cycle
//  imem_we     out  1        instruction-memory write strobe (one cycle per word)
//  imem_addr   out  ADDR_W   word address of write
//  imem_wdata  out  32       word to write
//  cpu_reset   out  1        active-high reset to MIPS core
//  busy        out  1        load in progress (HDR, DATA, WRITE, CSUM)
//  done        out  1        image loaded, core running
//  error       out  1        load aborted; core held in reset
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0,
//   cpu_reset=1, busy=0, done=0, error=0; partial word, byte counter, word count discarded.
//  Byte transfer = rx_valid & rx_ready at rising edge. rx_ready=1 only in HDR, DATA, CSUM.
//  States:
//   IDLE : start=1 -> HDR.
//   HDR  : accept 2 bytes, little-endian word count N[15:0]. After byte 2: N==0 or N>2**ADDR_W -> ERROR,
//          else -> DATA with word_idx=0, byte_idx=0.
//   DATA : accept bytes into word, byte_idx 0..3 -> bits [8*i+7:8*i]; on 4th byte -> WRITE.
//   WRITE: rx_ready=0; imem_we=1 for exactly one cycle, imem_addr=word_idx, imem_wdata=assembled word.
//          Next: word_idx==N-1 -> CSUM (if CHECKSUM_EN) else DONE; otherwise word_idx+1, -> DATA.
//   DONE : cpu_reset=0, done=1. start=1 -> HDR, cpu_reset=1 and done=0 from the next cycle.
//   ERROR: cpu_reset=1, error=1 (sticky). start=1 -> HDR, error cleared.
//  start ignored while busy. Latency byte->write: 4th byte accepted at edge k, imem_we high in cycle k..k+1.
//  Max throughput: 4 bytes per 5 cycles. word_idx is ADDR_W+1 bits wide so N=2**ADDR_W does not wrap;
//  last address written = 2**ADDR_W-1. imem_addr/imem_wdata hold last written value outside WRITE.
//  cpu_reset asserted through whole load; core is never released with a partial image.
//  Reset_n mid-load: immediate return to IDLE, memory contents already written left untouched.
// CONFIGURATION
//  CHECKSUM_EN defined: after last WRITE enter CSUM, accept one byte; equal to XOR of all 4N data
//   bytes -> DONE, else -> ERROR. Header bytes excluded from XOR; XOR cleared on entry to HDR.
//  CHECKSUM_EN undefined: no CSUM state, last WRITE -> DONE directly; stream is 2+4N bytes.
// TESTING
//  1 Reset_n=0 mid-DATA after 2 data bytes -> all outputs at reset values, cpu_reset=1, state IDLE.
//  2 start, bytes 02 00 | 20 08 00 05 | 00 00 00 08 -> imem_we at addr 0 data 32'h05000820,
//    addr 1 data 32'h08000000; then done=1, cpu_reset=0 (CHECKSUM_EN: append 0x25 first).
//  3 header 00 00 -> error=1, cpu_reset=1, no imem_we; start again with valid image -> done=1.
//  4 ADDR_W=2, header 05 00 -> ERROR; header 04 00 + 16 bytes -> writes addr 0..3, done=1, no wrap.
//  5 rx_valid toggled randomly -> words identical to gap-free run; rx_ready=0 in every WRITE cycle.
//  6 CHECKSUM_EN, one word 11 22 33 44 then 0x00 (expected 0x44) -> error=1, word 0 still written.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles little-endian words into instruction memory and
// holds the MIPS core in reset until a complete image is in place. Define CHECKSUM_EN for a trailing XOR byte.
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned IDX_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic               hdr_idx_q;
    logic [1:0]         byte_idx_q;
    logic [IDX_W-1:0]   word_idx_q;
    logic [15:0]        word_cnt_q;
    logic [23:0]        word_buf_q;
`ifdef CHECKSUM_EN
    logic [7:0]         csum_q;
`endif

    logic               fire;
    logic               start_ok;
    logic               last_word;
    logic [15:0]        hdr_n;
    logic               rx_ready_d, imem_we_d, cpu_reset_d, busy_d, done_d, error_d;

    // rx_ready mirrors the current state, so a transfer is a plain handshake
    assign fire      = rx_valid & rx_ready;
    assign start_ok  = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
    assign hdr_n     = {rx_data, word_cnt_q[7:0]};
    assign last_word = (32'(word_idx_q) + 32'd1) == 32'(word_cnt_q);

    // State register
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_HDR;
            S_HDR: begin
                if (fire && hdr_idx_q) begin
                    if (hdr_n == 16'd0 || 32'(hdr_n) > DEPTH) state_d = S_ERROR;
                    else                                      state_d = S_DATA;
                end
            end
            S_DATA:  if (fire && byte_idx_q == 2'd3) state_d = S_WRITE;
            S_WRITE: begin
                if (last_word) begin
`ifdef CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef CHECKSUM_EN
            S_CSUM:  if (fire) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
`endif
            S_DONE:  if (start) state_d = S_HDR;
            S_ERROR: if (start) state_d = S_HDR;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state; registered below so outputs track state_q
    always_comb begin
        rx_ready_d  = 1'b0;
        imem_we_d   = 1'b0;
        cpu_reset_d = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        case (state_d)
            S_HDR, S_DATA, S_CSUM: begin
                rx_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            S_WRITE: begin
                imem_we_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_DONE: begin
                cpu_reset_d = 1'b0;
                done_d      = 1'b1;
            end
            S_ERROR: error_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_ready  <= 1'b0;
            imem_we   <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rx_ready  <= rx_ready_d;
            imem_we   <= imem_we_d;
            cpu_reset <= cpu_reset_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

    // Header capture, word assembly and write address/data
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            hdr_idx_q  <= 1'b0;
            byte_idx_q <= 2'd0;
            word_idx_q <= '0;
            word_cnt_q <= 16'd0;
            word_buf_q <= 24'd0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
`ifdef CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            if (start_ok) begin
                hdr_idx_q <= 1'b0;
`ifdef CHECKSUM_EN
                csum_q    <= 8'd0;
`endif
            end
            if (fire && state_q == S_HDR) begin
                if (!hdr_idx_q) begin
                    word_cnt_q[7:0] <= rx_data;
                    hdr_idx_q       <= 1'b1;
                end else begin
                    word_cnt_q[15:8] <= rx_data;
                    word_idx_q       <= '0;
                    byte_idx_q       <= 2'd0;
                end
            end
            if (fire && state_q == S_DATA) begin
                byte_idx_q <= byte_idx_q + 2'd1;
`ifdef CHECKSUM_EN
                csum_q     <= csum_q ^ rx_data;
`endif
                case (byte_idx_q)
                    2'd0: word_buf_q[7:0]   <= rx_data;
                    2'd1: word_buf_q[15:8]  <= rx_data;
                    2'd2: word_buf_q[23:16] <= rx_data;
                    default: begin
                        imem_addr  <= word_idx_q[ADDR_W-1:0];
                        imem_wdata <= {rx_data, word_buf_q};
                    end
                endcase
            end
            if (state_q == S_WRITE) word_idx_q <= word_idx_q + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader (small ADDR_W so the capacity boundary is reachable).
module tb_imem_boot_loader;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          Reset_n = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready, imem_we, cpu_reset, busy, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    imem_boot_loader #(.ADDR_W(AW)) dut (
        .clock      (clock),
        .Reset_n    (Reset_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int              errors = 0;
    int              checks = 0;
    logic [7:0]      img[$];
    logic [AW+31:0]  exp_q[$];
    logic [31:0]     cap_data[$];
    logic [AW-1:0]   cap_addr[$];
    logic [AW+31:0]  exp_w;
    bit              exp_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the scoreboard of expected writes
    always @(negedge clock) begin
        if (Reset_n) begin
            checks++;
            if (cpu_reset !== ~done) begin
                errors++;
                $display("FAIL core_release: cpu_reset=%b done=%b", cpu_reset, done);
            end
            if (imem_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h", imem_addr, imem_wdata);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({imem_addr, imem_wdata} !== exp_w) begin
                        errors++;
                        $display("FAIL write: got %h/%h expected %h/%h", imem_addr, imem_wdata,
                                 exp_w[AW+31:32], exp_w[31:0]);
                    end
                end
                checks++;
                if (rx_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_write: got %b expected 0", rx_ready);
                end
                cap_addr.push_back(imem_addr);
                cap_data.push_back(imem_wdata);
            end
        end
    end

    // Model: derive expected writes and outcome from the byte image
    task automatic model_image();
        int n;
        logic [31:0] w;
`ifdef CHECKSUM_EN
        logic [7:0] x = 8'd0;
`endif
        n = int'({img[1], img[0]});
        exp_done = (n != 0) && (n <= int'(DEPTH));
        if (exp_done) begin
            for (int i = 0; i < n; i++) begin
                w = {img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]};
                exp_q.push_back({AW'(i), w});
`ifdef CHECKSUM_EN
                x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
`endif
            end
`ifdef CHECKSUM_EN
            exp_done = (img[2+4*n] == x);
`endif
        end
    endtask

    task automatic add_word(input logic [31:0] w);
        img.push_back(w[7:0]);
        img.push_back(w[15:8]);
        img.push_back(w[23:16]);
        img.push_back(w[31:24]);
    endtask

    task automatic add_csum();
`ifdef CHECKSUM_EN
        logic [7:0] x = 8'd0;
        for (int i = 2; i < img.size(); i++) x ^= img[i];
        img.push_back(x);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int t = 0;
        while (int'($urandom_range(0, 99)) < gap_pct) @(negedge clock);
        if (gap_pct > 0) start = ($urandom_range(0, 3) == 0);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL byte_timeout: rx_ready=%b expected 1", rx_ready);
        end
        @(negedge clock);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done === 1'b1 || error === 1'b1) && t < 40) begin
            @(negedge clock);
            t++;
        end
        check("done", 32'(done), 32'(exp_done));
        check("error", 32'(error), 32'(!exp_done));
        check("busy_end", 32'(busy), 32'd0);
        check("cpu_reset_end", 32'(cpu_reset), 32'(!exp_done));
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_image(input int gap_pct);
        model_image();
        cap_addr.delete();
        cap_data.delete();
        pulse_start();
        foreach (img[i]) send_byte(img[i], gap_pct);
        wait_end();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #2 Reset_n = 1'b0;
        #1 check_reset_values("por");
        repeat (2) @(negedge clock);
        Reset_n = 1'b1;
        @(negedge clock);

        // Two-word program from the core's point of view
        img = '{8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
        add_csum();
        send_image(0);
        check("t2_addr0", 32'(cap_addr[0]), 32'd0);
        check("t2_data0", cap_data[0], 32'h05000820);
        check("t2_addr1", 32'(cap_addr[1]), 32'd1);
        check("t2_data1", cap_data[1], 32'h08000000);

        // Reset in the middle of a word
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        check("t1_busy_before", 32'(busy), 32'd1);
        Reset_n = 1'b0;
        #1 check_reset_values("t1");
        @(negedge clock);
        Reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("t1_idle_ready", 32'(rx_ready), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Zero-length header, then recovery
        img = '{8'h00, 8'h00};
        send_image(0);
        check("t3_no_write", 32'(cap_data.size()), 32'd0);
        img = '{8'h01, 8'h00};
        add_word(32'hDEADBEEF);
        add_csum();
        send_image(0);
        check("t3_data", cap_data[0], 32'hDEADBEEF);

        // Capacity boundary
        img = '{8'h05, 8'h00};
        send_image(0);
        check("t4_no_write", 32'(cap_data.size()), 32'd0);
        img = '{8'h04, 8'h00};
        add_word(32'h11111111);
        add_word(32'h22222222);
        add_word(32'h33333333);
        add_word(32'h44444444);
        add_csum();
        send_image(0);
        check("t4_count", 32'(cap_data.size()), 32'd4);
        check("t4_addr3", 32'(cap_addr[3]), 32'd3);
        check("t4_data3", cap_data[3], 32'h44444444);

        // Stalled stream with stray start pulses
        img = '{8'h03, 8'h00};
        add_word(32'hA5A5_0001);
        add_word(32'h0000_00FF);
        add_word(32'h1234_5678);
        add_csum();
        send_image(50);
        check("t5_count", 32'(cap_data.size()), 32'd3);
        check("t5_data2", cap_data[2], 32'h12345678);

`ifdef CHECKSUM_EN
        // Bad checksum after a written word
        img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send_image(0);
        check("t6_data0", cap_data[0], 32'h44332211);
        check("t6_error", 32'(error), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
